// File: rtl/game_pkg.sv
// Shared game types and constants for the obstacle generator and its helpers.
// Contents: lane geometry, default board size, common counter widths, the
// generator FSM state type and the random-to-lane mapping.
package game_pkg;

  localparam int unsigned LANE_W           = 3;
  localparam int unsigned BOARD_WIDTH_DEF  = 9;
  localparam int unsigned BOARD_HEIGHT_DEF = 16;
  localparam int unsigned LFSR_W           = 8;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned SCORE_W          = 16;

  typedef enum logic {
    S_GAP   = 1'b0,
    S_BLOCK = 1'b1
  } gen_state_t;

  // Out-of-range random values fold onto the centre lane.
  function automatic logic [1:0] lane_from_rnd(input logic [1:0]   rnd,
                                               input int unsigned  num_lanes);
    return (32'(rnd) >= num_lanes) ? 2'd1 : rnd;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8/6/5/4, shifting left with feedback into bit 0.
// Ports:
//   clk   - clock
//   reset - synchronous active-high; loads seed
//   en    - advance one step this cycle
//   seed  - reset value (must be nonzero)
//   q     - current LFSR state
module lfsr8
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] lfsr_q;

  // Next state: shift on enable, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/obstacle_generator.sv
// Scrolling obstacle board generator. Every accepted tick shifts the board
// down one row, inserts a new top row from a gap/block FSM and raises
// update_collision for the following cycle. game_Over freezes everything.
// Ports:
//   clk              - clock
//   reset            - synchronous active-high, overrides all other inputs
//   tick             - advance request, one row per high cycle
//   game_Over        - freezes the generator
//   obstacle_data    - board rows, row 0 = top; bit 1 = obstacle
//   update_collision - one-cycle pulse after each shift
//   score            - count of non-empty rows shifted off the bottom
module obstacle_generator
  import game_pkg::*;
#(
  parameter int unsigned board_width  = BOARD_WIDTH_DEF,
  parameter int unsigned board_height = BOARD_HEIGHT_DEF,
  parameter int unsigned NUM_LANES    = 3,
  parameter int unsigned BLOCK_ROWS   = 2,
  parameter int unsigned INIT_GAP     = 4,
  parameter int unsigned MIN_GAP      = 1,
  parameter int unsigned LEVEL_UP     = 4,
  parameter logic [7:0]  LFSR_SEED    = 8'h01
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   game_Over,
  output logic [board_width-1:0] obstacle_data [0:board_height-1],
  output logic                   update_collision,
  output logic [SCORE_W-1:0]     score
);

  logic [board_width-1:0] rows_d [0:board_height-1];
  logic [board_width-1:0] rows_q [0:board_height-1];
  gen_state_t             state_d, state_q;
  logic [CNT_W-1:0]       row_cnt_d, row_cnt_q;
  logic [CNT_W-1:0]       gap_len_d, gap_len_q;
  logic [CNT_W-1:0]       blk_cnt_d, blk_cnt_q;
  logic [1:0]             lane_d, lane_q;
  logic [SCORE_W-1:0]     score_d, score_q;
  logic                   upd_d, upd_q;

  logic                   accept_c;
  logic [LFSR_W-1:0]      lfsr_val;
  logic                   lfsr_unused_c;
  logic [1:0]             lane_sel_c;
  logic [board_width-1:0] new_row_c;
  logic [CNT_W-1:0]       blk_inc_c;

  assign accept_c = tick & ~game_Over & ~reset;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (accept_c),
    .seed  (LFSR_SEED),
    .q     (lfsr_val)
  );

  // Only the low two LFSR bits pick a lane.
  assign lfsr_unused_c = ^lfsr_val[LFSR_W-1:2];

  // Next-state: row shift, gap/block FSM, difficulty and score.
  always_comb begin
    rows_d    = rows_q;
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    gap_len_d = gap_len_q;
    blk_cnt_d = blk_cnt_q;
    lane_d    = lane_q;
    score_d   = score_q;
    upd_d     = 1'b0;
    new_row_c = '0;
    blk_inc_c = blk_cnt_q + CNT_W'(1);

    // A block's lane is drawn on its first row and then held.
    lane_sel_c = lane_q;
    if (state_q == S_BLOCK && row_cnt_q == CNT_W'(BLOCK_ROWS)) begin
      lane_sel_c = lane_from_rnd(lfsr_val[1:0], NUM_LANES);
    end
    if (state_q == S_BLOCK) begin
      new_row_c = board_width'({LANE_W{1'b1}}) << (LANE_W * 32'(lane_sel_c));
    end

    if (accept_c) begin
      upd_d = 1'b1;
      for (int i = 1; i < int'(board_height); i++) begin
        rows_d[i] = rows_q[i-1];
      end
      rows_d[0] = new_row_c;

      if (rows_q[board_height-1] != '0 && score_q != {SCORE_W{1'b1}}) begin
        score_d = score_q + SCORE_W'(1);
      end

      row_cnt_d = row_cnt_q - CNT_W'(1);
      case (state_q)
        S_GAP: begin
          if (row_cnt_q == CNT_W'(1)) begin
            state_d   = S_BLOCK;
            row_cnt_d = CNT_W'(BLOCK_ROWS);
          end
        end
        S_BLOCK: begin
          lane_d = lane_sel_c;
          if (row_cnt_q == CNT_W'(1)) begin
            state_d   = S_GAP;
            blk_cnt_d = blk_inc_c;
            row_cnt_d = gap_len_q;
            // Level-up shortens this very next gap.
            if (blk_inc_c == CNT_W'(LEVEL_UP)) begin
              blk_cnt_d = '0;
              gap_len_d = (gap_len_q > CNT_W'(MIN_GAP)) ? gap_len_q - CNT_W'(1)
                                                        : CNT_W'(MIN_GAP);
              row_cnt_d = gap_len_d;
            end
          end
        end
        default: state_d = S_GAP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q    <= '{default: '0};
      state_q   <= S_GAP;
      row_cnt_q <= CNT_W'(INIT_GAP);
      gap_len_q <= CNT_W'(INIT_GAP);
      blk_cnt_q <= '0;
      lane_q    <= '0;
      score_q   <= '0;
      upd_q     <= 1'b0;
    end else begin
      rows_q    <= rows_d;
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      gap_len_q <= gap_len_d;
      blk_cnt_q <= blk_cnt_d;
      lane_q    <= lane_d;
      score_q   <= score_d;
      upd_q     <= upd_d;
    end
  end

  assign obstacle_data    = rows_q;
  assign update_collision = upd_q;
  assign score            = score_q;

endmodule

// File: tb/tb_obstacle_generator.sv
// Directed self-checking bench for obstacle_generator: reset state, LFSR lane
// pick, board scrolling, scoring, game-over freeze, difficulty ramp and reset
// in the middle of a block.
module tb_obstacle_generator;

  localparam int unsigned W = 9;
  localparam int unsigned H = 16;
  localparam logic [W-1:0] LANE1_ROW = 9'b000_111_000;

  logic          clk;
  logic          reset, tick, game_over;
  logic [W-1:0]  rows [0:H-1];
  logic          upd;
  logic [15:0]   score;

  logic          reset6, tick6, game_over6;
  logic [W-1:0]  rows6 [0:H-1];
  logic          upd6;
  logic [15:0]   score6;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_rows [0:H-1];

  obstacle_generator dut (
    .clk              (clk),
    .reset            (reset),
    .tick             (tick),
    .game_Over        (game_over),
    .obstacle_data    (rows),
    .update_collision (upd),
    .score            (score)
  );

  obstacle_generator #(
    .LEVEL_UP (1),
    .MIN_GAP  (1),
    .INIT_GAP (4)
  ) dut6 (
    .clk              (clk),
    .reset            (reset6),
    .tick             (tick6),
    .game_Over        (game_over6),
    .obstacle_data    (rows6),
    .update_collision (upd6),
    .score            (score6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < int'(H); i++) exp_rows[i] = '0;
  endtask

  task automatic chk_board(input string tag);
    for (int i = 0; i < int'(H); i++) begin
      chk($sformatf("%s_row%0d", tag, i), 32'(rows[i]), 32'(exp_rows[i]));
    end
  endtask

  function automatic logic [W-1:0] board_or();
    logic [W-1:0] acc = '0;
    for (int i = 0; i < int'(H); i++) acc |= rows[i];
    return acc;
  endfunction

  function automatic logic [W-1:0] board6_or();
    logic [W-1:0] acc = '0;
    for (int i = 0; i < int'(H); i++) acc |= rows6[i];
    return acc;
  endfunction

  task automatic pulse_tick(input string tag);
    tick = 1'b1;
    step();
    chk({tag, "_uc_on"}, 32'(upd), 32'd1);
    tick = 1'b0;
    step();
    chk({tag, "_uc_off"}, 32'(upd), 32'd0);
  endtask

  initial begin
    int           exp_gap [6];
    int           zrun, nzrun, gi;
    logic [W-1:0] r, prev;
    logic [W-1:0] exp6 [7];

    exp_gap = '{4, 3, 2, 1, 1, 1};
    exp6    = '{9'h000, 9'h000, 9'h000, 9'h000, LANE1_ROW, LANE1_ROW, 9'h000};

    reset = 1'b1; tick = 1'b0; game_over = 1'b0;
    reset6 = 1'b1; tick6 = 1'b0; game_over6 = 1'b0;
    step();
    step();

    // 1: reset state, idle for 10 cycles
    chk("rst_board", 32'(board_or()), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_uc", 32'(upd), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_val), 32'h01);
    reset = 1'b0;
    reset6 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_board", 32'(board_or()), 32'd0);
      chk("idle_score", 32'(score), 32'd0);
      chk("idle_uc", 32'(upd), 32'd0);
    end

    // 2: four isolated ticks stay in the initial gap
    for (int t = 0; t < 4; t++) pulse_tick("gap_tick");
    chk("gap_board", 32'(board_or()), 32'd0);
    chk("lfsr_after4", 32'(dut.lfsr_val), 32'h11);

    // 3: first block in lane 1, two rows tall, then a gap row
    clear_exp();
    pulse_tick("blk_tick5");
    exp_rows[0] = LANE1_ROW;
    chk_board("tick5");
    pulse_tick("blk_tick6");
    exp_rows[1] = LANE1_ROW;
    chk_board("tick6");
    pulse_tick("blk_tick7");
    exp_rows[0] = '0;
    exp_rows[2] = LANE1_ROW;
    chk_board("tick7");

    // 4: continuous ticks from reset, scoring as block rows fall off
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk($sformatf("cont_uc_t%0d", k), 32'(upd), 32'd1);
      chk($sformatf("cont_score_t%0d", k), 32'(score), (k <= 20) ? 32'd0 : 32'(k - 20));
    end
    tick = 1'b0;

    // 5: game over after tick 10 freezes board, score and lfsr
    reset = 1'b1;
    step();
    reset = 1'b0;
    tick = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("pre_go_uc", 32'(upd), 32'd1);
    game_over = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("go_uc", 32'(upd), 32'd0);
    end
    clear_exp();
    exp_rows[4] = LANE1_ROW;
    exp_rows[5] = LANE1_ROW;
    chk_board("frozen");
    chk("frozen_score", 32'(score), 32'd0);
    chk("frozen_lfsr", 32'(dut.lfsr_val), 32'h71);
    reset = 1'b1;
    step();
    chk("go_rst_board", 32'(board_or()), 32'd0);
    chk("go_rst_score", 32'(score), 32'd0);
    chk("go_rst_uc", 32'(upd), 32'd0);
    chk("go_rst_lfsr", 32'(dut.lfsr_val), 32'h01);
    reset = 1'b0; tick = 1'b0; game_over = 1'b0;
    step();

    // 6: LEVEL_UP=1 ramps the gap 4 -> 3 -> 2 -> 1 and floors at 1
    reset6 = 1'b1;
    step();
    reset6 = 1'b0;
    tick6 = 1'b1;
    zrun = 0; nzrun = 0; gi = 0; prev = '0;
    for (int k = 0; k < 24; k++) begin
      step();
      r = rows6[0];
      if (r == '0) begin
        if (nzrun != 0) begin
          chk("blk_len", 32'(nzrun), 32'(2));
          nzrun = 0;
        end
        zrun++;
      end else begin
        if (zrun != 0) begin
          chk($sformatf("gap_len%0d", gi), 32'(zrun), 32'(exp_gap[gi < 6 ? gi : 5]));
          gi++;
          zrun = 0;
        end
        chk("one_lane", 32'(r == 9'h007 || r == 9'h038 || r == 9'h1C0), 32'd1);
        if (nzrun == 1) chk("lane_held", 32'(r), 32'(prev));
        prev = r;
        nzrun++;
      end
    end
    chk("gap_count", 32'(gi), 32'd6);

    // reset right after a block's first row leaves no partial block
    reset6 = 1'b1;
    tick6 = 1'b0;
    step();
    reset6 = 1'b0;
    tick6 = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("mid_blk_row0", 32'(rows6[0]), 32'(LANE1_ROW));
    reset6 = 1'b1;
    step();
    chk("mid_rst_board", 32'(board6_or()), 32'd0);
    chk("mid_rst_score", 32'(score6), 32'd0);
    chk("mid_rst_uc", 32'(upd6), 32'd0);
    reset6 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("post_rst_row0_t%0d", k + 1), 32'(rows6[0]), 32'(exp6[k]));
    end
    chk("post_rst_row1", 32'(rows6[1]), 32'(LANE1_ROW));
    chk("post_rst_row2", 32'(rows6[2]), 32'(LANE1_ROW));
    tick6 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
